// File: rtl/nerv_mem_responder.sv
// nerv_mem_responder: responder for the core's data-memory and TLB-walk ports.
// Backs every port with one word-addressed RAM.
// Data accesses run through an IDLE/WAIT/RESP FSM that holds `stall` high while the access is in flight.
// The TLB-walk ports are plain registered reads with one cycle of latency.
// Optional feature macro NERV_MEMRESP_RANDLAT_EN: adds a 4-bit `lat_rand` input that sets the per-access latency.
module nerv_mem_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_mem_read_valid,
   input  logic [63:0] io_mem_read_addr,
   input  logic [6:0]  io_mem_read_memWidth,
   output logic [31:0] io_mem_read_data,
   input  logic        io_mem_write_valid,
   input  logic [63:0] io_mem_write_addr,
   input  logic [6:0]  io_mem_write_memWidth,
   input  logic [63:0] io_mem_write_data,
   input  logic        io_tlb_Anotherread_0_valid,
   input  logic [63:0] io_tlb_Anotherread_0_addr,
   output logic [31:0] io_tlb_Anotherread_0_data,
   input  logic        io_tlb_Anotherread_1_valid,
   input  logic [63:0] io_tlb_Anotherread_1_addr,
   output logic [31:0] io_tlb_Anotherread_1_data,
   input  logic        io_tlb_Anotherread_2_valid,
   input  logic [63:0] io_tlb_Anotherread_2_addr,
   output logic [31:0] io_tlb_Anotherread_2_data,
`ifdef NERV_MEMRESP_RANDLAT_EN
   input  logic [3:0]  lat_rand,
`endif
   output logic        stall,
   output logic        resp_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int AW    = DEPTH_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   logic [31:0] r_ram [DEPTH];

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_stall;
   logic        r_resp_err;
   logic [31:0] r_read_data;
   logic        r_rd_valid;
   logic [63:0] r_rd_addr;
   logic [6:0]  r_rd_width;
   logic        r_wr_valid;
   logic [63:0] r_wr_addr;
   logic [6:0]  r_wr_width;
   logic [31:0] r_wr_data;

   logic [3:0]    w_lat_m1;
   logic          w_err;
   logic [AW-1:0] w_rd_idx;
   logic [AW-1:0] w_wr_idx;
   logic [3:0]    w_wr_be;
   logic [31:0]   w_wr_bitmask;
   logic [31:0]   w_wr_shift;
   logic [31:0]   w_wr_merged;
   logic [31:0]   w_rd_word;
   logic [31:0]   w_rd_shift;
   logic [31:0]   w_rd_wmask;
   logic [31:0]   w_rd_data;
   logic          w_resp_now;
   logic          w_commit;

   // An access is illegal for an unsupported width, a misaligned address, or an address beyond the RAM.
   function automatic logic f_bad(input logic [63:0] addr, input logic [6:0] width);
      logic bad_w;
      logic bad_a;
      logic bad_r;
      bad_w = !(width == 7'd8 || width == 7'd16 || width == 7'd32);
      bad_a = (width == 7'd16 && addr[0]) || (width == 7'd32 && addr[1:0] != 2'b00);
      bad_r = |(addr >> (DEPTH_LOG2 + 2));
      return bad_w | bad_a | bad_r;
   endfunction

   // Byte enables for a legal access, placed at the byte lane selected by the low address bits.
   function automatic logic [3:0] f_be(input logic [6:0] width, input logic [1:0] off);
      logic [3:0] be;
      case (width)
         7'd8:    be = 4'b0001;
         7'd16:   be = 4'b0011;
         default: be = 4'b1111;
      endcase
      return be << off;
   endfunction

`ifdef NERV_MEMRESP_RANDLAT_EN
   // A random latency of 0 is treated as 1, so at least one stall cycle always occurs.
   assign w_lat_m1 = (lat_rand == 4'd0) ? 4'd0 : lat_rand - 4'd1;
`else
   assign w_lat_m1 = 4'(LATENCY - 1);
`endif

   assign w_err = (r_rd_valid && f_bad(r_rd_addr, r_rd_width)) ||
                  (r_wr_valid && f_bad(r_wr_addr, r_wr_width));

   assign w_rd_idx = r_rd_addr[AW+1:2];
   assign w_wr_idx = r_wr_addr[AW+1:2];
   assign w_wr_be  = f_be(r_wr_width, r_wr_addr[1:0]);

   for (genvar gi = 0; gi < 4; gi++) begin : gen_bitmask
      assign w_wr_bitmask[8*gi +: 8] = {8{w_wr_be[gi]}};
   end

   assign w_wr_shift  = r_wr_data << {r_wr_addr[1:0], 3'b000};
   assign w_wr_merged = (r_ram[w_wr_idx] & ~w_wr_bitmask) | (w_wr_shift & w_wr_bitmask);

   // A combined read+write request must observe its own write.
   assign w_rd_word  = (r_wr_valid && w_wr_idx == w_rd_idx) ? w_wr_merged : r_ram[w_rd_idx];
   assign w_rd_shift = w_rd_word >> {r_rd_addr[1:0], 3'b000};
   assign w_rd_wmask = (r_rd_width == 7'd8)  ? 32'h0000_00FF :
                       (r_rd_width == 7'd16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   assign w_rd_data  = w_rd_shift & w_rd_wmask;

   assign w_resp_now = (r_state == S_WAIT) && (r_cnt == 4'd0);
   assign w_commit   = w_resp_now && r_wr_valid && !w_err;

   // Data-access FSM: it latches the request in IDLE, counts down the stall cycles in WAIT, and presents the response for one cycle in RESP.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_stall     <= 1'b0;
         r_resp_err  <= 1'b0;
         r_read_data <= 32'd0;
         r_rd_valid  <= 1'b0;
         r_rd_addr   <= 64'd0;
         r_rd_width  <= 7'd0;
         r_wr_valid  <= 1'b0;
         r_wr_addr   <= 64'd0;
         r_wr_width  <= 7'd0;
         r_wr_data   <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_read_data <= 32'd0;
               r_resp_err  <= 1'b0;
               if (io_mem_read_valid || io_mem_write_valid) begin
                  r_rd_valid <= io_mem_read_valid;
                  r_rd_addr  <= io_mem_read_addr;
                  r_rd_width <= io_mem_read_memWidth;
                  r_wr_valid <= io_mem_write_valid;
                  r_wr_addr  <= io_mem_write_addr;
                  r_wr_width <= io_mem_write_memWidth;
                  r_wr_data  <= io_mem_write_data[31:0];
                  r_cnt      <= w_lat_m1;
                  r_stall    <= 1'b1;
                  r_state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_stall     <= 1'b0;
                  r_resp_err  <= w_err;
                  r_read_data <= (r_rd_valid && !w_err) ? w_rd_data : 32'd0;
                  r_state     <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               r_read_data <= 32'd0;
               r_resp_err  <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // RAM write port: the write commits on the edge that enters RESP, and it is suppressed on error or reset.
   always_ff @(posedge clock) begin
      if (w_commit) begin
         r_ram[w_wr_idx] <= w_wr_merged;
      end
   end

   logic        w_tlb_valid [3];
   logic [63:0] w_tlb_addr  [3];

   assign w_tlb_valid[0] = io_tlb_Anotherread_0_valid;
   assign w_tlb_valid[1] = io_tlb_Anotherread_1_valid;
   assign w_tlb_valid[2] = io_tlb_Anotherread_2_valid;
   assign w_tlb_addr[0]  = io_tlb_Anotherread_0_addr;
   assign w_tlb_addr[1]  = io_tlb_Anotherread_1_addr;
   assign w_tlb_addr[2]  = io_tlb_Anotherread_2_addr;

   for (genvar gi = 0; gi < 3; gi++) begin : gen_tlb
      logic [31:0] r_data;
      logic        w_in_range;
      assign w_in_range = ~|(w_tlb_addr[gi] >> (DEPTH_LOG2 + 2));
      // TLB walk read: registered, independent of the FSM, and it sees the RAM contents before any same-edge write.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            r_data <= 32'd0;
         end else if (w_tlb_valid[gi] && w_in_range) begin
            r_data <= r_ram[w_tlb_addr[gi][AW+1:2]];
         end else begin
            r_data <= 32'd0;
         end
      end
   end

   assign io_tlb_Anotherread_0_data = gen_tlb[0].r_data;
   assign io_tlb_Anotherread_1_data = gen_tlb[1].r_data;
   assign io_tlb_Anotherread_2_data = gen_tlb[2].r_data;

   assign stall            = r_stall;
   assign resp_err         = r_resp_err;
   assign io_mem_read_data = r_read_data;

   // The upper write-data bits and the TLB byte offset are intentionally ignored.
   logic w_unused_bits;
   assign w_unused_bits = &{1'b0, io_mem_write_data[63:32],
                            io_tlb_Anotherread_0_addr[1:0],
                            io_tlb_Anotherread_1_addr[1:0],
                            io_tlb_Anotherread_2_addr[1:0]};

endmodule

// File: tb/tb_nerv_mem_responder.sv
`define CHK(TAG, OBS, EXP) \
   checks++; \
   assert ((OBS) === (EXP)) else begin \
      failures++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
   end

module tb_nerv_mem_responder;
   logic        clock;
   logic        reset;
   logic        rd_valid;
   logic [63:0] rd_addr;
   logic [6:0]  rd_width;
   logic [31:0] rd_data;
   logic        wr_valid;
   logic [63:0] wr_addr;
   logic [6:0]  wr_width;
   logic [63:0] wr_data;
   logic        t0_valid, t1_valid, t2_valid;
   logic [63:0] t0_addr, t1_addr, t2_addr;
   logic [31:0] t0_data, t1_data, t2_data;
   logic        stall;
   logic        resp_err;

   int checks = 0;
   int failures = 0;

   int          a_stalls;
   logic [31:0] a_data;
   logic        a_err;
   logic [31:0] a_idle_data;
   logic        a_timeout;

   nerv_mem_responder dut (
      .clock                      (clock),
      .reset                      (reset),
      .io_mem_read_valid          (rd_valid),
      .io_mem_read_addr           (rd_addr),
      .io_mem_read_memWidth       (rd_width),
      .io_mem_read_data           (rd_data),
      .io_mem_write_valid         (wr_valid),
      .io_mem_write_addr          (wr_addr),
      .io_mem_write_memWidth      (wr_width),
      .io_mem_write_data          (wr_data),
      .io_tlb_Anotherread_0_valid (t0_valid),
      .io_tlb_Anotherread_0_addr  (t0_addr),
      .io_tlb_Anotherread_0_data  (t0_data),
      .io_tlb_Anotherread_1_valid (t1_valid),
      .io_tlb_Anotherread_1_addr  (t1_addr),
      .io_tlb_Anotherread_1_data  (t1_data),
      .io_tlb_Anotherread_2_valid (t2_valid),
      .io_tlb_Anotherread_2_addr  (t2_addr),
      .io_tlb_Anotherread_2_data  (t2_data),
      .stall                      (stall),
      .resp_err                   (resp_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic access(input logic rv, input logic [63:0] ra, input logic [6:0] rw,
                         input logic wv, input logic [63:0] wa, input logic [6:0] ww,
                         input logic [63:0] wd,
                         output int stalls, output logic [31:0] data, output logic err,
                         output logic [31:0] idle_data, output logic timeout);
      rd_valid = rv; rd_addr = ra; rd_width = rw;
      wr_valid = wv; wr_addr = wa; wr_width = ww; wr_data = wd;
      @(posedge clock);
      #1;
      rd_valid = 1'b0;
      wr_valid = 1'b0;
      stalls = 0;
      timeout = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (stall) stalls++;
         else begin
            timeout = 1'b0;
            break;
         end
      end
      checks++;
      if (timeout) begin
         failures++;
         $error("FAIL access_timeout rv=%0d ra=%0h wv=%0d wa=%0h: stall never dropped", rv, ra, wv, wa);
      end
      data = rd_data;
      err = resp_err;
      @(negedge clock);
      idle_data = rd_data;
      $display("access rv=%0d ra=%0h rw=%0d wv=%0d wa=%0h ww=%0d wd=%0h -> stalls=%0d data=%0h err=%0d",
               rv, ra, rw, wv, wa, ww, wd, stalls, data, err);
   endtask

   initial begin
      reset = 1'b0;
      rd_valid = 1'b0; rd_addr = 64'd0; rd_width = 7'd32;
      wr_valid = 1'b0; wr_addr = 64'd0; wr_width = 7'd32; wr_data = 64'd0;
      t0_valid = 1'b0; t0_addr = 64'd0;
      t1_valid = 1'b0; t1_addr = 64'd0;
      t2_valid = 1'b0; t2_addr = 64'd0;
      repeat (3) @(negedge clock);
      checks++;
      if (stall !== 1'b0 || resp_err !== 1'b0 || rd_data !== 32'd0 ||
          t0_data !== 32'd0 || t1_data !== 32'd0 || t2_data !== 32'd0) begin
         failures++;
         $error("FAIL reset_state stall=%0b err=%0b rdata=%0h tlb0=%0h tlb1=%0h tlb2=%0h",
                stall, resp_err, rd_data, t0_data, t1_data, t2_data);
      end
      $display("reset stall=%0b err=%0b rdata=%0h", stall, resp_err, rd_data);
      `CHK("rst_stall", stall, 1'b0)
      `CHK("rst_err", resp_err, 1'b0)
      `CHK("rst_rdata", rd_data, 32'd0)
      `CHK("rst_tlb0", t0_data, 32'd0)
      `CHK("rst_tlb2", t2_data, 32'd0)
      reset = 1'b1;
      @(negedge clock);

      access(1'b0, 64'd0, 7'd32, 1'b1, 64'h10, 7'd32, 64'h0, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("prefill_tmo", a_timeout, 1'b0)
      `CHK("prefill_stalls", a_stalls, 2)

      wr_valid = 1'b1; wr_addr = 64'h10; wr_width = 7'd32; wr_data = 64'hAABBCCDD;
      @(posedge clock);
      #1 wr_valid = 1'b0;
      @(negedge clock);
      `CHK("t1_wait_stall", stall, 1'b1)
      reset = 1'b0;
      @(negedge clock);
      `CHK("t1_abort_stall", stall, 1'b0)
      `CHK("t1_abort_err", resp_err, 1'b0)
      reset = 1'b1;
      @(negedge clock);
      access(1'b1, 64'h10, 7'd32, 1'b0, 64'd0, 7'd32, 64'd0, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("t1_read_data", a_data, 32'h0)
      `CHK("t1_read_err", a_err, 1'b0)

      access(1'b0, 64'd0, 7'd32, 1'b1, 64'h20, 7'd32, 64'h11223344, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("t2_wr_stalls", a_stalls, 2)
      `CHK("t2_wr_err", a_err, 1'b0)
      access(1'b1, 64'h22, 7'd8, 1'b0, 64'd0, 7'd32, 64'd0, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("t2_rd_stalls", a_stalls, 2)
      `CHK("t2_rd_data", a_data, 32'h00000022)
      `CHK("t2_rd_err", a_err, 1'b0)
      `CHK("t2_idle_data", a_idle_data, 32'h0)

      access(1'b0, 64'd0, 7'd32, 1'b1, 64'h24, 7'd32, 64'h11223344, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      access(1'b0, 64'd0, 7'd32, 1'b1, 64'h26, 7'd16, 64'hFFFFFFFF_DEADBEEF, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("t3_hw_err", a_err, 1'b0)
      access(1'b1, 64'h24, 7'd32, 1'b0, 64'd0, 7'd32, 64'd0, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("t3_rd32", a_data, 32'hBEEF3344)
      access(1'b1, 64'h26, 7'd16, 1'b0, 64'd0, 7'd32, 64'd0, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("t3_rd16", a_data, 32'h0000BEEF)
      access(1'b1, 64'h25, 7'd8, 1'b0, 64'd0, 7'd32, 64'd0, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("t3_rd8", a_data, 32'h00000033)

      access(1'b1, 64'h21, 7'd32, 1'b0, 64'd0, 7'd32, 64'd0, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("t4_misal_err", a_err, 1'b1)
      `CHK("t4_misal_data", a_data, 32'h0)
      `CHK("t4_misal_stalls", a_stalls, 2)
      access(1'b1, 64'h20, 7'd64, 1'b0, 64'd0, 7'd32, 64'd0, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("t4_w64_err", a_err, 1'b1)
      `CHK("t4_w64_data", a_data, 32'h0)
      access(1'b0, 64'd0, 7'd32, 1'b1, 64'h22, 7'd32, 64'hFFFFFFFF, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("t4_badwr_err", a_err, 1'b1)
      access(1'b1, 64'h20, 7'd32, 1'b0, 64'd0, 7'd32, 64'd0, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("t4_nowrite", a_data, 32'h11223344)
      `CHK("t4_ok_err", a_err, 1'b0)

      access(1'b1, 64'h1000, 7'd32, 1'b0, 64'd0, 7'd32, 64'd0, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("t5_oor_err", a_err, 1'b1)
      `CHK("t5_oor_data", a_data, 32'h0)
      t0_valid = 1'b1; t0_addr = 64'h20;
      @(negedge clock);
      `CHK("t5_tlb0_ok", t0_data, 32'h11223344)
      $display("tlb0 addr=20 data=%0h", t0_data);
      t0_addr = 64'h1000;
      @(negedge clock);
      `CHK("t5_tlb0_oor", t0_data, 32'h0)
      $display("tlb0 addr=1000 data=%0h", t0_data);
      t0_valid = 1'b0; t0_addr = 64'h20;
      @(negedge clock);
      `CHK("t5_tlb0_novalid", t0_data, 32'h0)
      $display("tlb0 valid=0 data=%0h", t0_data);

      rd_valid = 1'b1; rd_addr = 64'h24; rd_width = 7'd32;
      @(posedge clock);
      #1 rd_valid = 1'b0;
      @(negedge clock);
      `CHK("t6_stall_a", stall, 1'b1)
      t1_valid = 1'b1; t1_addr = 64'h23;
      @(negedge clock);
      `CHK("t6_tlb1", t1_data, 32'h11223344)
      `CHK("t6_stall_b", stall, 1'b1)
      $display("tlb1 addr=23 during WAIT data=%0h stall=%0d", t1_data, stall);
      t1_valid = 1'b0;
      @(negedge clock);
      `CHK("t6_resp_stall", stall, 1'b0)
      `CHK("t6_resp_data", rd_data, 32'hBEEF3344)
      @(negedge clock);
      `CHK("t6_tlb1_off", t1_data, 32'h0)

      access(1'b1, 64'h20, 7'd32, 1'b1, 64'h21, 7'd8, 64'h5A, a_stalls, a_data, a_err, a_idle_data, a_timeout);
      `CHK("rw_data", a_data, 32'h11225A44)
      `CHK("rw_err", a_err, 1'b0)
      `CHK("rw_tmo", a_timeout, 1'b0)

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
